// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver with a scancode FIFO.
//
//   The receiver synchronises and glitch-filters kclk/kdata, then deframes
//   11-bit frames (start, 8 data bits LSB first, odd parity, stop).
//   A frame must also arrive without a mid-frame gap longer than the
//   inter-bit timeout.
//   Each good byte is pushed into a circular FIFO with a valid/ready drain,
//   and it is also shifted into a 32-bit keycode history.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   kclk/kdata  raw PS/2 pins (asynchronous)
//   out_byte    FIFO head, registered
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts head when out_valid & out_ready
//   keycodeout  last four good bytes, newest in [7:0]
//   parity_err  one-cycle pulse: frame dropped, bad parity
//   frame_err   one-cycle pulse: frame dropped, stop bit 0 or timeout
//   overflow    one-cycle pulse: good byte dropped, FIFO full
//   fifo_count  FIFO occupancy
//
// Receiver FSM
//   state    | meaning
//   ---------+----------------------------------------------
//   S_IDLE   | waiting for a falling edge with kdata low (start bit)
//   S_DATA   | collecting 8 data bits, LSB first
//   S_PARITY | next falling edge carries the parity bit
//   S_STOP   | next falling edge carries the stop bit; frame is judged
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kclk,
  input  logic                          kdata,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   keycodeout,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int FCW = $clog2(FILTER_LEN);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input synchronisers and filters ----------------
  // Index 0 is kclk, index 1 is kdata.
  logic [1:0]     sync1_q, sync1_d;
  logic [1:0]     sync2_q, sync2_d;
  logic [1:0]     filt_q, filt_d;
  logic [FCW-1:0] flt_cnt_q [2];
  logic [FCW-1:0] flt_cnt_d [2];
  logic           kclk_prev_q, kclk_prev_d;
  logic           fall;
  logic           kdata_f;

  always_comb begin
    sync1_d     = {kdata, kclk};
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    kclk_prev_d = filt_q[0];
    for (int i = 0; i < 2; i++) begin
      flt_cnt_d[i] = '0;
      // The filtered value flips on the FILTER_LEN-th consecutive differing sample.
      if (sync2_q[i] != filt_q[i]) begin
        if (flt_cnt_q[i] == FLT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          flt_cnt_d[i] = flt_cnt_q[i] + FCW'(1);
        end
      end
    end
  end

  assign fall    = kclk_prev_q & ~filt_q[0];
  assign kdata_f = filt_q[1];

  // ---------------- receiver FSM ----------------
  state_t         state_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TW-1:0]  tmr_q;
  logic           parity_err_q;
  logic           frame_err_q;

  logic           stop_eval;
  logic           stop_bad;
  logic           parity_bad;
  logic           good_byte;
  logic           timeout;

  always_comb begin
    stop_eval  = (state_q == S_STOP) && fall;
    stop_bad   = stop_eval && !kdata_f;
    // Odd parity: parity bit must equal the inverted XOR of the data.
    parity_bad = stop_eval && kdata_f && (parity_q != ~^shift_q);
    good_byte  = stop_eval && kdata_f && (parity_q == ~^shift_q);
    // A strobe in the same cycle wins over an expiring timer.
    timeout    = (state_q != S_IDLE) && !fall && (tmr_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmr_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (fall) begin
        tmr_q <= TMR_LOAD;
      end else if (state_q != S_IDLE && tmr_q != '0) begin
        tmr_q <= tmr_q - TW'(1);
      end

      if (timeout) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fall && !kdata_f) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end
          S_DATA: begin
            if (fall) begin
              shift_q[bit_idx_q] <= kdata_f;
              bit_idx_q          <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (fall) begin
              parity_q <= kdata_f;
              state_q  <= S_STOP;
            end
          end
          S_STOP: begin
            if (fall) begin
              state_q      <= S_IDLE;
              frame_err_q  <= stop_bad;
              parity_err_q <= parity_bad;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- FIFO and keycode history ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   kc_q, kc_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          full;
  logic          push_ok;

  always_comb begin
    pop        = (count_q != '0) && out_ready;
    full       = (count_q == CNT_FULL);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_ok    = good_byte && (!full || pop);
    overflow_d = good_byte && full && !pop;
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    kc_d       = good_byte ? {kc_q[23:0], shift_q} : kc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      filt_q       <= 2'b11;
      flt_cnt_q[0] <= '0;
      flt_cnt_q[1] <= '0;
      kclk_prev_q  <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      kc_q         <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      flt_cnt_q[0] <= flt_cnt_d[0];
      flt_cnt_q[1] <= flt_cnt_d[1];
      kclk_prev_q  <= kclk_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      kc_q         <= kc_d;
      overflow_q   <= overflow_d;
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign out_byte   = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign keycodeout = kc_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int FILT  = 8;
  localparam int TMO   = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kclk = 1'b1;
  logic        kdata = 1'b1;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic [31:0] keycodeout;
  logic        parity_err, frame_err, overflow;
  logic [3:0]  fifo_count;

  ps2_rx_fifo #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .keycodeout(keycodeout), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard of bytes expected at the FIFO output
  logic [7:0] sb_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          par_seen = 0, frm_seen = 0, ovf_seen = 0;
  int          kc_cyc = 0, frm_cyc = 0;
  logic [31:0] kc_prev = '0;

  always @(negedge clk) begin
    if (parity_err === 1'b1) par_seen++;
    if (frame_err === 1'b1) begin frm_seen++; frm_cyc = cyc; end
    if (overflow === 1'b1) ovf_seen++;
    if (keycodeout !== kc_prev) begin kc_cyc = cyc; kc_prev = keycodeout; end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got byte 0x%0h, expected no pending byte", out_byte);
      end else begin
        check("pop_byte", {24'h0, out_byte}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int last_fall_cyc = 0;
  int stop_cyc = 0;
  int lat = 11;

  task automatic ps2_bit(logic b);
    kdata = b;
    wait_cyc(HALF/2);
    kclk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    kclk = 1'b1;
    wait_cyc(HALF/2);
  endtask

  // pop_lat > 0 raises out_ready for one cycle so that it coincides with the push
  task automatic send_frame(logic [7:0] d, logic par_flip, logic stop_zero, int pop_lat);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    kdata = ~stop_zero;
    wait_cyc(HALF/2);
    kclk = 1'b0;
    stop_cyc = cyc;
    if (pop_lat > 0) begin
      wait_cyc(pop_lat - 1);
      out_ready = 1'b1;
      wait_cyc(1);
      out_ready = 1'b0;
      wait_cyc(HALF - pop_lat);
    end else begin
      wait_cyc(HALF);
    end
    kclk  = 1'b1;
    kdata = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    sb_q.delete();
    wait_cyc(1);
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (fifo_count != 0 && k < 4*DEPTH) begin wait_cyc(1); k++; end
    out_ready = 1'b0;
    wait_cyc(1);
    check("drain_count", {28'h0, fifo_count}, 32'h0);
    check("drain_valid", {31'h0, out_valid}, 32'h0);
    check("drain_sb_left", sb_q.size(), 32'h0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        par_flip;
    logic        stop_zero;
    logic        push;
    int          exp_par;
    int          exp_frm;
    int          exp_ovf;
    int          exp_cnt;
    logic [31:0] exp_kc;
  } vec_t;

  vec_t vecs[16];

  task automatic run_vec(int i);
    int p0 = par_seen;
    int f0 = frm_seen;
    int o0 = ovf_seen;
    if (vecs[i].push) sb_q.push_back(vecs[i].data);
    send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_zero, 0);
    check($sformatf("v%0d_count", i), {28'h0, fifo_count}, vecs[i].exp_cnt);
    check($sformatf("v%0d_keycode", i), keycodeout, vecs[i].exp_kc);
    check($sformatf("v%0d_parity_err", i), par_seen - p0, vecs[i].exp_par);
    check($sformatf("v%0d_frame_err", i), frm_seen - f0, vecs[i].exp_frm);
    check($sformatf("v%0d_overflow", i), ovf_seen - o0, vecs[i].exp_ovf);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    n_fail++;
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, f0, o0, d;
    //              data  pf  sz  push par frm ovf cnt keycode
    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 0, 0, 1, 32'h0000001C};
    vecs[1]  = '{8'hF0, 0, 0, 1, 0, 0, 0, 1, 32'h000000F0};
    vecs[2]  = '{8'h1C, 0, 0, 1, 0, 0, 0, 2, 32'h0000F01C};
    vecs[3]  = '{8'h23, 0, 0, 1, 0, 0, 0, 3, 32'h00F01C23};
    vecs[4]  = '{8'h1C, 1, 0, 0, 1, 0, 0, 0, 32'h00F01C23};
    vecs[5]  = '{8'h1C, 0, 1, 0, 0, 1, 0, 0, 32'h00F01C23};
    vecs[6]  = '{8'h1C, 1, 1, 0, 0, 1, 0, 0, 32'h00F01C23};
    vecs[7]  = '{8'h01, 0, 0, 1, 0, 0, 0, 1, 32'h00000001};
    vecs[8]  = '{8'h02, 0, 0, 1, 0, 0, 0, 2, 32'h00000102};
    vecs[9]  = '{8'h03, 0, 0, 1, 0, 0, 0, 3, 32'h00010203};
    vecs[10] = '{8'h04, 0, 0, 1, 0, 0, 0, 4, 32'h01020304};
    vecs[11] = '{8'h05, 0, 0, 1, 0, 0, 0, 5, 32'h02030405};
    vecs[12] = '{8'h06, 0, 0, 1, 0, 0, 0, 6, 32'h03040506};
    vecs[13] = '{8'h07, 0, 0, 1, 0, 0, 0, 7, 32'h04050607};
    vecs[14] = '{8'h08, 0, 0, 1, 0, 0, 0, 8, 32'h05060708};
    vecs[15] = '{8'h09, 0, 0, 0, 0, 0, 1, 8, 32'h06070809};

    // reset state
    wait_cyc(3);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_byte", {24'h0, out_byte}, 32'h0);
    check("rst_keycode", keycodeout, 32'h0);
    check("rst_count", {28'h0, fifo_count}, 32'h0);
    check("rst_pulses", {29'h0, parity_err, frame_err, overflow}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // single good byte, then one ready pulse
    run_vec(0);
    lat = kc_cyc - stop_cyc;
    check("push_latency_sane", {31'h0, (lat >= 2 && lat <= 30)}, 32'h1);
    check("t1_valid", {31'h0, out_valid}, 32'h1);
    check("t1_byte", {24'h0, out_byte}, 32'h1C);
    out_ready = 1'b1;
    wait_cyc(1);
    out_ready = 1'b0;
    wait_cyc(1);
    check("t1_valid_after_pop", {31'h0, out_valid}, 32'h0);

    // three bytes queued, drained in order
    do_reset();
    for (int i = 1; i <= 3; i++) run_vec(i);
    drain();

    // parity error, stop error, both
    for (int i = 4; i <= 6; i++) run_vec(i);

    // FILTER_LEN-1 cycle glitch and a falling edge with kdata high: both ignored
    p0 = par_seen; f0 = frm_seen;
    kdata = 1'b0;
    wait_cyc(2);
    kclk = 1'b0;
    wait_cyc(FILT - 1);
    kclk = 1'b1;
    wait_cyc(20);
    kdata = 1'b1;
    wait_cyc(20);
    kclk = 1'b0;
    wait_cyc(HALF);
    kclk = 1'b1;
    wait_cyc(HALF);
    check("glitch_count", {28'h0, fifo_count}, 32'h0);
    sb_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("glitch_next_count", {28'h0, fifo_count}, 32'h1);
    check("glitch_next_keycode", keycodeout, 32'hF01C231C);
    check("glitch_no_errors", (par_seen - p0) + (frm_seen - f0), 32'h0);
    drain();

    // inter-bit timeout
    do_reset();
    f0 = frm_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cyc(3*TMO);
    check("timeout_frame_err", frm_seen - f0, 32'h1);
    d = frm_cyc - last_fall_cyc;
    check("timeout_delay_window", {31'h0, (d >= TMO && d <= TMO + lat + 5)}, 32'h1);
    check("timeout_count", {28'h0, fifo_count}, 32'h0);
    sb_q.push_back(8'h2B);
    send_frame(8'h2B, 1'b0, 1'b0, 0);
    check("after_timeout_keycode", keycodeout, 32'h0000002B);
    check("after_timeout_count", {28'h0, fifo_count}, 32'h1);
    check("after_timeout_no_err", frm_seen - f0, 32'h1);
    drain();

    // fill past depth: overflow on the ninth byte
    do_reset();
    for (int i = 7; i <= 15; i++) run_vec(i);
    drain();

    // full FIFO with a pop in the push cycle: no overflow, count stays full
    for (int b = 8'h11; b <= 8'h18; b++) begin
      sb_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 1'b0, 0);
    end
    check("refill_count", {28'h0, fifo_count}, 32'h8);
    o0 = ovf_seen;
    sb_q.push_back(8'h19);
    send_frame(8'h19, 1'b0, 1'b0, lat);
    check("simul_no_overflow", ovf_seen - o0, 32'h0);
    check("simul_count", {28'h0, fifo_count}, 32'h8);
    check("simul_keycode", keycodeout, 32'h16171819);
    drain();

    // reset in the middle of a frame
    sb_q.push_back(8'h42);
    send_frame(8'h42, 1'b0, 1'b0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    do_reset();
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_byte", {24'h0, out_byte}, 32'h0);
    check("midrst_keycode", keycodeout, 32'h0);
    check("midrst_count", {28'h0, fifo_count}, 32'h0);
    wait_cyc(4*HALF);
    p0 = par_seen; f0 = frm_seen;
    sb_q.push_back(8'h75);
    send_frame(8'h75, 1'b0, 1'b0, 0);
    check("midrst_next_keycode", keycodeout, 32'h00000075);
    check("midrst_next_count", {28'h0, fifo_count}, 32'h1);
    check("midrst_next_byte", {24'h0, out_byte}, 32'h75);
    check("midrst_no_errors", (par_seen - p0) + (frm_seen - f0), 32'h0);
    drain();

    summary();
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver: synchronises and glitch-filters `kclk`/`kdata`, deframes 11-bit frames, checks odd parity and stop bit, and enforces an inter-bit timeout.
Good bytes are pushed into a scancode FIFO with a valid/ready drain port, and also shifted into a 32-bit keycode history register.
Sits between the keyboard pins and the Tetris input decoder, replacing the fixed single-register receiver.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before filtered `kclk`/`kdata` change (≥2).
TIMEOUT_CYCLES, 200000, `clk` cycles allowed between filtered `kclk` falling edges mid-frame (2 ms at 100 MHz).
FIFO_DEPTH, 8, scancode FIFO entries (power of two, ≥2).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
kclk  input  1  raw PS/2 clock pin (asynchronous)
kdata  input  1  raw PS/2 data pin (asynchronous)
out_byte  output  8  head-of-FIFO scancode
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts `out_byte` when `out_valid` & `out_ready`
keycodeout  output  32  history of last four good bytes, newest in [7:0]
parity_err  output  1  one-cycle pulse: frame discarded, bad parity
frame_err  output  1  one-cycle pulse: frame discarded, stop bit 0 or timeout
overflow  output  1  one-cycle pulse: good byte dropped, FIFO full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, `rst`=1 at posedge): FSM=IDLE; counters cleared; filtered `kclk`/`kdata`=1; synchronisers=1; FIFO emptied.
  Outputs: `out_valid`=0, `out_byte`=0, `keycodeout`=0, all error pulses 0, `fifo_count`=0.
- Reset mid-frame discards the partial frame.
- Input path: 2-flop synchroniser per pin, then a filter counter. A filtered output changes only after FILTER_LEN consecutive equal samples differing from the current value.
- A falling edge is filtered `kclk` going 1→0, detected as a one-cycle strobe. All bit sampling uses filtered `kdata` in the strobe cycle.
- FSM states:
  - IDLE: on strobe with `kdata`=0 go to DATA, bit index=0. A strobe with `kdata`=1 is ignored and the FSM stays in IDLE.
  - DATA: on strobe, shift `kdata` into shift[index], LSB first. After the 8th bit go to PARITY.
  - PARITY: on strobe, latch the parity bit and go to STOP.
  - STOP: on strobe, evaluate the frame and return to IDLE.
- Frame check (odd parity, i.e. valid when the parity bit = ~^data):
  - Stop bit 0 → `frame_err` pulse; the byte is discarded even if parity is also bad.
  - Else parity bad → `parity_err` pulse; byte discarded.
  - Else the byte is good.
- Timeout: the cycle counter resets on every strobe and counts only outside IDLE. When it reaches TIMEOUT_CYCLES: `frame_err` pulse, FSM→IDLE, partial byte discarded.
- Latency: the stop-bit strobe occurs in cycle N. Error pulses are registered at N+1. For a good byte the FIFO write and the `keycodeout` update both occur at N+1.
  `out_valid` rises at N+1 if the FIFO was empty; `out_byte` is valid the same cycle.
- `keycodeout` = {keycodeout[23:0], byte} on every good byte, regardless of FIFO state, including on overflow.
- FIFO:
  - Circular buffer; `out_byte` is the registered head.
  - Pop occurs when `out_valid` & `out_ready`.
  - Push of a good byte while full and no pop in the same cycle: byte dropped, `overflow` pulse, contents unchanged.
  - Push and pop in the same cycle while full: both take effect, no overflow, count unchanged.
  - Push and pop in the same cycle with count=1: head advances to the new byte, `out_valid` stays 1.
  - `out_ready` while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- At most one of `parity_err`/`frame_err`/`overflow` pulses per frame.

Test Plan:
1. Setup for all scenarios: `clk` 100 MHz; PS/2 half-period 20 µs with `kdata` changed 10 µs before each `kclk` fall.
   Stimulus: send 0x1C with parity bit 0, stop bit 1.
   Required: `out_valid`=1 with `out_byte`=0x1C, `keycodeout`=0x0000001C, no error pulses, `fifo_count`=1. Pulse `out_ready` once → `out_valid`=0.
2. Hold `out_ready`=0; send 0xF0, 0x1C, 0x23.
   Required: `fifo_count`=3, `keycodeout`=0x00F01C23. Draining yields 0xF0, 0x1C, 0x23 in order.
3. Send 0x1C with parity bit 1 → one `parity_err` pulse, FIFO unchanged, `keycodeout` unchanged.
   Send 0x1C with stop bit 0 → one `frame_err` pulse.
   Send a 1-cycle `kclk` glitch while idle → no state change.
4. Send start bit plus 3 data bits, then hold `kclk`=1 for 3 ms → one `frame_err` ≈2 ms after the last fall.
   A following good frame 0x2B is received correctly.
5. Hold `out_ready`=0 and send 9 bytes 0x01–0x09 (FIFO_DEPTH=8) → `fifo_count`=8, one `overflow` on 0x09, `keycodeout`=0x06070809. Draining yields 0x01–0x08.
   Then full FIFO with `out_ready`=1 during the stop-bit write → no overflow, count stays 8.
6. Assert `rst` for one cycle during the DATA state → all outputs 0 and FIFO empty. The next full frame 0x75 is received correctly.
